// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: opcodes, FSM
// encoding, timeout default and the access-legality / RAM-opcode helpers.
package mem_access_ctrl_pkg;

  localparam int TIMEOUT_CYC_DEF = 16;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FIN   = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // True when the opcode matches the direction, the address is naturally
  // aligned for the access size and lies inside the 512-byte RAM window.
  function automatic logic access_ok(input logic rw, input logic [5:0] op,
                                     input logic [31:0] addr);
    logic op_ok;
    logic align_ok;
    op_ok    = 1'b0;
    align_ok = 1'b0;
    if (rw) begin
      case (op)
        OP_LB, OP_LBU: begin op_ok = 1'b1; align_ok = 1'b1;             end
        OP_LH, OP_LHU: begin op_ok = 1'b1; align_ok = ~addr[0];          end
        OP_LW:         begin op_ok = 1'b1; align_ok = (addr[1:0] == 2'b00); end
        default:       begin op_ok = 1'b0; align_ok = 1'b0;             end
      endcase
    end else begin
      case (op)
        OP_SB:   begin op_ok = 1'b1; align_ok = 1'b1;             end
        OP_SH:   begin op_ok = 1'b1; align_ok = ~addr[0];          end
        OP_SW:   begin op_ok = 1'b1; align_ok = (addr[1:0] == 2'b00); end
        default: begin op_ok = 1'b0; align_ok = 1'b0;             end
      endcase
    end
    return op_ok && align_ok && (addr[31:9] == 23'd0);
  endfunction

  // The RAM only knows signed load codes; unsigned variants are folded onto
  // them and the extension happens on our side.
  function automatic logic [5:0] ram_op_map(input logic [5:0] op);
    case (op)
      OP_LBU:  return OP_LB;
      OP_LHU:  return OP_LH;
      default: return op;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Controller-to-RAM bus.
// Handshake: the controller raises MOV with RamRW/RamAddr/RamDataIn/RamOP
// stable and keeps them so until it samples MOC=1 on a rising edge; the RAM
// presents read data on RamDataOut in the same cycle it raises MOC.
interface mem_access_ctrl_if;
  logic        MOV;
  logic        RamRW;
  logic [31:0] RamAddr;
  logic [31:0] RamDataIn;
  logic [5:0]  RamOP;
  logic [31:0] RamDataOut;
  logic        MOC;

  modport master (output MOV, RamRW, RamAddr, RamDataIn, RamOP,
                  input  RamDataOut, MOC);
  modport slave  (input  MOV, RamRW, RamAddr, RamDataIn, RamOP,
                  output RamDataOut, MOC);
endinterface

// File: rtl/mem_load_extend.sv
// Combinational load extension of right-justified RAM read data.
module mem_load_extend
  import mem_access_ctrl_pkg::*;
(
  input  logic [5:0]  OP,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut
);

  // Sign/zero extend according to the original (unmapped) load opcode.
  always_comb begin
    DataOut = DataIn;
    case (OP)
      OP_LB:   DataOut = {{24{DataIn[7]}}, DataIn[7:0]};
      OP_LBU:  DataOut = {24'd0, DataIn[7:0]};
      OP_LH:   DataOut = {{16{DataIn[15]}}, DataIn[15:0]};
      OP_LHU:  DataOut = {16'd0, DataIn[15:0]};
      default: DataOut = DataIn;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: accepts one load/store request at a time,
// checks legality, runs the MOV/MOC handshake with a timeout and returns
// the extended load result.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               Clk,
  input  logic               Clr,
  input  logic               Req,
  input  logic               RW,
  input  logic [5:0]         OP,
  input  logic [31:0]        Addr,
  input  logic [31:0]        WData,
  mem_access_ctrl_if.master  ram,
  output logic [31:0]        RData,
  output logic               Done,
  output logic               Busy,
  output logic               AddrErr,
  output logic               Timeout,
  output state_t             state_dbg
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t             state, next_state;
  logic               rw_q;
  logic [5:0]         op_q;
  logic [31:0]        addr_q, wdata_q, rdata_q, ext_data;
  logic [CNT_W-1:0]   wait_cnt;
  logic               addr_err_q, timeout_q;
  logic               mov, accept, req_ok, wait_expired;

  assign accept       = (state == ST_IDLE) && Req;
  assign req_ok       = access_ok(RW, OP, Addr);
  assign wait_expired = (state == ST_WAIT) && !ram.MOC &&
                        (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  mem_load_extend u_ext (
    .OP      (op_q),
    .DataIn  (ram.RamDataOut),
    .DataOut (ext_data)
  );

  // State register; Clr aborts any access at once.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next state plus MOV/Done decode.
  always_comb begin
    next_state = state;
    mov        = 1'b0;
    Done       = 1'b0;
    case (state)
      ST_IDLE:  if (Req) next_state = req_ok ? ST_ISSUE : ST_ERR;
      ST_ISSUE: begin
        mov        = 1'b1;
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        mov = 1'b1;
        if (ram.MOC)          next_state = ST_FIN;
        else if (wait_expired) next_state = ST_ERR;
      end
      ST_FIN, ST_ERR: begin
        Done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Request capture; these registers drive the RAM bus for the whole access.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      rw_q    <= 1'b1;
      op_q    <= 6'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      rw_q    <= RW;
      op_q    <= OP;
      addr_q  <= Addr;
      wdata_q <= WData;
    end
  end

  // Counts WAIT cycles that passed without MOC.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr)                     wait_cnt <= '0;
    else if (state != ST_WAIT)   wait_cnt <= '0;
    else if (!ram.MOC)           wait_cnt <= wait_cnt + 1'b1;
  end

  // Error flags: cleared on acceptance, held until the next accepted Req.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      addr_err_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else if (accept) begin
      addr_err_q <= !req_ok;
      timeout_q  <= 1'b0;
    end else if (wait_expired) begin
      timeout_q  <= 1'b1;
    end
  end

  // Load result captured on the completing edge of a read.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr)                                       rdata_q <= 32'd0;
    else if ((state == ST_WAIT) && ram.MOC && rw_q) rdata_q <= ext_data;
  end

  assign ram.MOV       = mov;
  assign ram.RamRW     = rw_q;
  assign ram.RamAddr   = addr_q;
  assign ram.RamDataIn = wdata_q;
  assign ram.RamOP     = ram_op_map(op_q);
  assign RData         = rdata_q;
  assign Busy          = (state != ST_IDLE);
  assign AddrErr       = addr_err_q;
  assign Timeout       = timeout_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte RAM responder, reference model of the
// access rules, directed scenarios followed by randomized accesses.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Clr;
  always #5 Clk = ~Clk;

  logic        Req, RW;
  logic [5:0]  OP;
  logic [31:0] Addr, WData, RData;
  logic        Done, Busy, AddrErr, Timeout;
  state_t      state_dbg;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .Clk(Clk), .Clr(Clr), .Req(Req), .RW(RW), .OP(OP), .Addr(Addr),
    .WData(WData), .ram(bus), .RData(RData), .Done(Done), .Busy(Busy),
    .AddrErr(AddrErr), .Timeout(Timeout), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0]  ram_mem [512];   // contents as written through the DUT bus
  logic [7:0]  ref_mem [512];   // contents predicted by the model
  logic [31:0] exp_q[$];
  logic [31:0] exp_rdata;
  logic        exp_addr_err, exp_timeout;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [5:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    if (op == OP_LW || op == OP_SW) return 4;
    return 0;
  endfunction

  function automatic bit is_load(input logic [5:0] op);
    return op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU || op == OP_LW;
  endfunction

  function automatic bit is_store(input logic [5:0] op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction

  function automatic bit model_legal(input logic rw, input logic [5:0] op, input logic [31:0] addr);
    int sz = op_size(op);
    if (rw && !is_load(op)) return 0;
    if (!rw && !is_store(op)) return 0;
    if ((addr % 32'(sz)) != 0) return 0;
    if (addr >= 32'd512) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] addr);
    logic [31:0] v = 0;
    int sz = op_size(op);
    for (int i = 0; i < sz; i++) v = (v << 8) | 32'(ref_mem[(int'(addr[8:0]) + i) % 512]);
    if (op == OP_LB && v >= 32'h80)   v = v + 32'hFFFFFF00;
    if (op == OP_LH && v >= 32'h8000) v = v + 32'hFFFF0000;
    return v;
  endfunction

  function automatic logic [5:0] model_ram_op(input logic [5:0] op);
    if (op == OP_LBU) return OP_LB;
    if (op == OP_LHU) return OP_LH;
    return op;
  endfunction

  // ---------------- RAM responder (big-endian byte RAM) ----------------
  task automatic ram_respond();
    int a = int'(bus.RamAddr[8:0]);
    case (bus.RamOP)
      6'b100000: bus.RamDataOut = {24'd0, ram_mem[a]};
      6'b100001: bus.RamDataOut = {16'd0, ram_mem[a], ram_mem[(a+1)%512]};
      6'b100011: bus.RamDataOut = {ram_mem[a], ram_mem[(a+1)%512], ram_mem[(a+2)%512], ram_mem[(a+3)%512]};
      6'b101000: ram_mem[a] = bus.RamDataIn[7:0];
      6'b101001: begin
        ram_mem[a] = bus.RamDataIn[15:8];
        ram_mem[(a+1)%512] = bus.RamDataIn[7:0];
      end
      6'b101011: begin
        ram_mem[a] = bus.RamDataIn[31:24];
        ram_mem[(a+1)%512] = bus.RamDataIn[23:16];
        ram_mem[(a+2)%512] = bus.RamDataIn[15:8];
        ram_mem[(a+3)%512] = bus.RamDataIn[7:0];
      end
      default: bus.RamDataOut = $urandom;
    endcase
  endtask

  // ---------------- driver ----------------
  // delay = WAIT cycles with MOC=0 before the RAM completes; >= TO never completes.
  task automatic do_access(input logic rw, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input int delay);
    bit          legal = model_legal(rw, op, addr);
    bit          to    = legal && (delay >= TO);
    int          exp_done, exp_mov, cyc, movs, unstable, sz;
    bit          got_done;
    logic [31:0] snap_addr, snap_din;
    logic [5:0]  snap_op;
    logic        snap_rw;

    if (!legal)  begin exp_done = 1;        exp_mov = 0;         end
    else if (to) begin exp_done = TO + 2;   exp_mov = TO + 1;    end
    else         begin exp_done = delay + 3; exp_mov = delay + 2; end
    if (legal && !to && rw) exp_rdata = model_load(op, addr);
    exp_q.push_back(exp_rdata);
    sz = op_size(op);
    if (legal && !to && !rw)
      for (int i = 0; i < sz; i++)
        ref_mem[(int'(addr[8:0]) + i) % 512] = wdata[8*(sz-1-i) +: 8];

    @(negedge Clk);
    check("idle_busy", 32'(Busy), 0);
    check("idle_done", 32'(Done), 0);
    check("held_addr_err", 32'(AddrErr), 32'(exp_addr_err));
    check("held_timeout", 32'(Timeout), 32'(exp_timeout));
    Req = 1'b1; RW = rw; OP = op; Addr = addr; WData = wdata;
    @(negedge Clk);
    cyc = 1; movs = 0; unstable = 0; got_done = 0;
    snap_addr = 0; snap_din = 0; snap_op = 0; snap_rw = 0;
    while (!got_done && cyc <= 40) begin
      if (bus.MOV === 1'b1) begin
        movs++;
        if (movs == 1) begin
          check("ram_addr", bus.RamAddr, addr);
          check("ram_rw", 32'(bus.RamRW), 32'(rw));
          check("ram_din", bus.RamDataIn, wdata);
          check("ram_op", 32'(bus.RamOP), 32'(model_ram_op(op)));
          snap_addr = bus.RamAddr; snap_din = bus.RamDataIn;
          snap_op = bus.RamOP; snap_rw = bus.RamRW;
        end else if (bus.RamAddr !== snap_addr || bus.RamDataIn !== snap_din ||
                     bus.RamOP !== snap_op || bus.RamRW !== snap_rw) begin
          unstable++;
        end
      end
      if (Done === 1'b1) begin
        got_done = 1;
        check("done_cycle", 32'(cyc), 32'(exp_done));
        check("mov_cycles", 32'(movs), 32'(exp_mov));
        check("mov_at_done", 32'(bus.MOV), 0);
        check("busy_at_done", 32'(Busy), 1);
        check("addr_err", 32'(AddrErr), 32'(!legal));
        check("timeout", 32'(Timeout), 32'(to));
        check("rdata", RData, exp_q.pop_front());
      end
      // stimulus for the next edge: spurious Req noise, RAM response
      Req = 1'($urandom_range(0, 1)); RW = 1'($urandom); OP = 6'($urandom);
      Addr = $urandom; WData = $urandom;
      bus.MOC = 1'b0;
      if (bus.MOV === 1'b1 && !got_done) begin
        if (movs == 1) bus.MOC = 1'($urandom_range(0, 1));
        else if (movs - 1 > delay) begin
          bus.MOC = 1'b1;
          ram_respond();
        end
      end
      if (!got_done) begin
        @(negedge Clk);
        cyc++;
      end
    end
    if (!got_done) begin
      check("done_budget", 0, 1);
      void'(exp_q.pop_front());
      Clr = 1'b1; #1; Clr = 1'b0;
      exp_rdata = 0; exp_addr_err = 0; exp_timeout = 0;
    end else begin
      Req = 1'b0;
      bus.MOC = 1'b0;
      if (legal) check("bus_stable", 32'(unstable), 0);
      if (legal && !to && !rw)
        for (int i = 0; i < sz; i++)
          check("ram_byte", 32'(ram_mem[(int'(addr[8:0]) + i) % 512]),
                32'(ref_mem[(int'(addr[8:0]) + i) % 512]));
      exp_addr_err = !legal;
      exp_timeout  = to;
    end
  endtask

  // Start an lw, then hit Clr while the access sits in WAIT.
  task automatic do_clr_abort();
    @(negedge Clk);
    Req = 1'b1; RW = 1'b1; OP = OP_LW; Addr = 32'h10; WData = 0;
    @(negedge Clk);
    Req = 1'b0;
    @(negedge Clk);
    check("abort_mov_before", 32'(bus.MOV), 1);
    #2 Clr = 1'b1;
    #1;
    check("abort_mov", 32'(bus.MOV), 0);
    check("abort_busy", 32'(Busy), 0);
    check("abort_done", 32'(Done), 0);
    check("abort_rdata", RData, 0);
    @(negedge Clk);
    Clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("abort_no_done", 32'(Done), 0);
    end
    exp_rdata = 0; exp_addr_err = 0; exp_timeout = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [5:0] op_tab [8];
    logic [5:0] op;
    logic [31:0] addr;
    logic rw;
    int sz, dly;

    op_tab[0] = OP_LB; op_tab[1] = OP_LBU; op_tab[2] = OP_LH; op_tab[3] = OP_LHU;
    op_tab[4] = OP_LW; op_tab[5] = OP_SB;  op_tab[6] = OP_SH; op_tab[7] = OP_SW;

    for (int i = 0; i < 512; i++) begin
      ram_mem[i] = 8'($urandom);
      ref_mem[i] = ram_mem[i];
    end
    Clr = 1'b1; Req = 0; RW = 0; OP = 0; Addr = 0; WData = 0;
    bus.MOC = 1'b0; bus.RamDataOut = 0;
    exp_rdata = 0; exp_addr_err = 0; exp_timeout = 0;

    #12;
    check("rst_busy", 32'(Busy), 0);
    check("rst_done", 32'(Done), 0);
    check("rst_mov", 32'(bus.MOV), 0);
    check("rst_addr_err", 32'(AddrErr), 0);
    check("rst_timeout", 32'(Timeout), 0);
    check("rst_rdata", RData, 0);
    check("rst_ram_addr", bus.RamAddr, 0);
    check("rst_ram_din", bus.RamDataIn, 0);
    check("rst_ram_op", 32'(bus.RamOP), 0);
    check("rst_ram_rw", 32'(bus.RamRW), 1);
    @(negedge Clk);
    Clr = 1'b0;

    // word read
    ram_mem[16] = 8'hDE; ram_mem[17] = 8'hAD; ram_mem[18] = 8'hBE; ram_mem[19] = 8'hEF;
    for (int i = 16; i < 20; i++) ref_mem[i] = ram_mem[i];
    do_access(1'b1, OP_LW, 32'h10, 32'h0, 0);
    // byte signed / unsigned
    ram_mem[32] = 8'h80; ref_mem[32] = 8'h80;
    do_access(1'b1, OP_LB, 32'h20, 32'h0, 1);
    do_access(1'b1, OP_LBU, 32'h20, 32'h0, 0);
    // halfword store then load
    do_access(1'b0, OP_SH, 32'h30, 32'h12348001, 2);
    do_access(1'b1, OP_LH, 32'h30, 32'h0, 0);
    // misaligned word, then a valid access clears AddrErr
    do_access(1'b1, OP_LW, 32'h02, 32'h0, 0);
    do_access(1'b1, OP_LW, 32'h10, 32'h0, 0);
    // out-of-window and wrong-direction opcodes
    do_access(1'b1, OP_LB, 32'h200, 32'h0, 0);
    do_access(1'b0, OP_LW, 32'h40, 32'h0, 0);
    // timeout, then recovery
    do_access(1'b1, OP_LW, 32'h10, 32'h0, TO + 5);
    do_access(1'b0, OP_SW, 32'h1FC, 32'hCAFEF00D, 0);
    // Clr during WAIT, then a normal access
    do_clr_abort();
    do_access(1'b1, OP_LW, 32'h1FC, 32'h0, 1);

    // randomized accesses
    for (int n = 0; n < 60; n++) begin
      op = op_tab[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      rw = is_load(op);
      if ($urandom_range(0, 7) == 0) rw = ~rw;
      sz = op_size(op);
      addr = 32'($urandom_range(0, 511));
      if (sz != 0 && $urandom_range(0, 3) != 0) addr = addr - (addr % 32'(sz));
      if ($urandom_range(0, 15) == 0) addr = addr | 32'h1000;
      dly = $urandom_range(0, 3);
      if ($urandom_range(0, 11) == 0) dly = TO + 3;
      do_access(rw, op, addr, $urandom, dly);
    end

    @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, 16, maximum cycles to wait for MOC before abort.
REQ-002 SHALL have port: Clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port: Clr  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: Req  input  1  access request from control unit.
REQ-005 SHALL have port: RW  input  1  1 = read, 0 = write.
REQ-006 SHALL have port: OP  input  6  load/store opcode.
REQ-007 SHALL have port: Addr  input  32  byte address.
REQ-008 SHALL have port: WData  input  32  store data, right-justified.
REQ-009 SHALL have port: RamDataOut  input  32  read data from the byte RAM.
REQ-010 SHALL have port: MOC  input  1  memory-operation-complete from the RAM.
REQ-011 SHALL have port: MOV  output  1  memory-operation-valid to the RAM.
REQ-012 SHALL have port: RamRW  output  1  read/write to the RAM.
REQ-013 SHALL have port: RamAddr  output  32  address to the RAM.
REQ-014 SHALL have port: RamDataIn  output  32  write data to the RAM.
REQ-015 SHALL have port: RamOP  output  6  opcode to the RAM.
REQ-016 SHALL have port: RData  output  32  extended load result.
REQ-017 SHALL have port: Done  output  1  one-cycle completion pulse.
REQ-018 SHALL have port: Busy  output  1  access in progress.
REQ-019 SHALL have ports: AddrErr, Timeout  output  1 each  error flags.

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT, FIN, ERR; Busy=1 in every state except IDLE.
REQ-021 In IDLE with Req=1, SHALL register RW, OP, Addr and WData on the same edge, clear AddrErr and Timeout, and leave IDLE; Req is ignored in every other state.
REQ-022 Supported opcodes: loads 100000 lb, 100100 lbu, 100001 lh, 100101 lhu, 100011 lw; stores 101000 sb, 101001 sh, 101011 sw.
REQ-023 SHALL go to ERR instead of ISSUE in any of these cases: opcode unsupported for the given RW; word access with Addr[1:0]!=0; halfword access with Addr[0]!=0; Addr[31:9]!=0.
REQ-024 ISSUE: SHALL assert MOV=1 for exactly one cycle, ignore MOC, then go to WAIT.
REQ-025 SHALL keep MOV=1 throughout WAIT and hold RamAddr/RamRW/RamDataIn/RamOP stable from ISSUE through WAIT.
REQ-026 RamOP SHALL map lbu to 100000 and lhu to 100001; all other opcodes pass through unchanged.
REQ-027 RamDataIn SHALL equal the registered WData, unmodified.
REQ-028 WAIT: SHALL sample MOC each cycle; on MOC=1 go to FIN, and for a read register the extended RamDataOut into RData.
REQ-029 Extension SHALL be: lb sign-extends [7:0]; lbu zero-extends [7:0]; lh sign-extends [15:0]; lhu zero-extends [15:0]; lw passes all 32 bits.
REQ-030 A write SHALL leave RData unchanged.
REQ-031 A wait counter SHALL count WAIT cycles; if TIMEOUT_CYC cycles pass without MOC, SHALL go to ERR with Timeout=1.
REQ-032 FIN: SHALL drive MOV=0 and Done=1 for one cycle, then return to IDLE.
REQ-033 ERR: SHALL drive MOV=0 and Done=1 for one cycle, set AddrErr or Timeout accordingly, then return to IDLE.
REQ-034 AddrErr and Timeout SHALL hold their value until the next accepted Req.
REQ-035 SHALL never assert MOV for an access that results in AddrErr.
REQ-036 Minimum latency from Req accepted to Done SHALL be 3 cycles (ISSUE, WAIT with MOC=1, FIN).
REQ-037 SHALL accept a back-to-back Req in the cycle after Done, in IDLE.

Reset
REQ-038 Clr=1 SHALL immediately force state IDLE and MOV=0, Done=0, Busy=0, AddrErr=0, Timeout=0, RData=0, RamAddr=0, RamDataIn=0, RamOP=0, RamRW=1, and clear the wait counter.
REQ-039 Clr asserted mid-access SHALL abort it with no Done pulse.

Structure
REQ-040 A shared package SHALL hold the opcode constants, the state encoding and the TIMEOUT_CYC default.
REQ-041 Load extension SHALL be a combinational sub-module named mem_load_extend (inputs OP and 32-bit data; output 32-bit data).

Verification
REQ-042 Word read: RAM[0x10..0x13]=DE AD BE EF; lw Addr=0x10 -> MOV pulse, Done at cycle 3, RData=0xDEADBEEF.
REQ-043 Byte signed/unsigned: RAM[0x20]=0x80; lb -> RData=0xFFFFFF80; lbu -> RData=0x00000080 with RamOP=100000.
REQ-044 Halfword store then load: sh Addr=0x30, WData=0x12348001 -> RAM[0x30]=80, RAM[0x31]=01; lh -> RData=0xFFFF8001.
REQ-045 Misaligned access: lw Addr=0x02 -> MOV never asserted, Done with AddrErr=1; the next valid Req clears AddrErr.
REQ-046 Timeout: MOC held 0 -> Done with Timeout=1 after TIMEOUT_CYC WAIT cycles, MOV drops to 0.
REQ-047 Clr pulse during WAIT -> MOV=0 immediately, Busy=0, no Done; the next Req completes normally.
